// File: rtl/task_scheduler_fsm.sv
// Task dispatcher: walks a loadable memory of control/instruction frames and issues
// instruction frames to a core array under NO/ACQ/REL/END fence ordering.
module task_scheduler_fsm #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned TM_DEPTH  = 64,
  parameter int unsigned TM_WIDTH  = 64,
  parameter int unsigned REG_W     = 8,
  parameter int unsigned IF_W      = 4,
  parameter int unsigned AW        = $clog2(TM_DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tm_we,
  input  logic [AW-1:0]                tm_waddr,
  input  logic [TM_WIDTH-1:0]          tm_wdata,
  input  logic                         run,
  input  logic [NUM_CORES-1:0]         Ready,
  output logic [NUM_CORES-1:0]         Start,
  output logic [TM_WIDTH-1:0]          Insn_Data,
  output logic [NUM_CORES-1:0]         Init_R0_Vect,
  output logic [NUM_CORES*REG_W-1:0]   Init_R0,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned CavLsb = 2;
  localparam int unsigned R0vLsb = CavLsb + NUM_CORES;
  localparam int unsigned IfnLsb = R0vLsb + NUM_CORES;
  localparam int unsigned R0Lsb  = IfnLsb + IF_W;

  typedef enum logic [1:0] {FenceNo = 2'd0, FenceAcq = 2'd1, FenceRel = 2'd2, FenceEnd = 2'd3} fence_e;
  typedef enum logic [1:0] {StIdle, StFetch, StIssue, StDone} state_e;

  logic [TM_WIDTH-1:0] mem [TM_DEPTH];

  state_e                       state_q, state_d;
  logic [AW-1:0]                tp_q, tp_d;
  logic [IF_W-1:0]              cnt_q, cnt_d;
  fence_e                       fence_q, fence_d;
  logic [NUM_CORES-1:0]         cav_q, cav_d;
  logic [NUM_CORES-1:0]         start_q, start_d;
  logic [TM_WIDTH-1:0]          insn_q, insn_d;
  logic [NUM_CORES-1:0]         r0v_q, r0v_d;
  logic [NUM_CORES*REG_W-1:0]   r0_q, r0_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;

  logic [TM_WIDTH-1:0]          frame;
  fence_e                       f_fence;
  logic [NUM_CORES-1:0]         f_cav;
  logic [IF_W-1:0]              f_ifn;
  logic                         gate;
  logic                         writable;

  assign frame   = mem[tp_q];
  assign f_fence = fence_e'(frame[1:0]);
  assign f_cav   = frame[CavLsb +: NUM_CORES];
  assign f_ifn   = frame[IfnLsb +: IF_W];

  assign writable = (state_q == StIdle) || (state_q == StDone);

  // Memory is deliberately not reset so a program survives a mid-run reset.
  always_ff @(posedge clk) begin
    if (tm_we && writable) begin
      mem[tm_waddr] <= tm_wdata;
    end
  end

  // END and release-type ordering both need the whole array idle.
  always_comb begin
    if (f_fence == FenceEnd || fence_q == FenceAcq || f_fence == FenceRel) begin
      gate = &Ready;
    end else begin
      gate = ~|(f_cav & ~Ready);
    end
  end

  always_comb begin
    state_d = state_q;
    tp_d    = tp_q;
    cnt_d   = cnt_q;
    fence_d = fence_q;
    cav_d   = cav_q;
    start_d = '0;
    insn_d  = insn_q;
    r0v_d   = r0v_q;
    r0_d    = r0_q;

    case (state_q)
      StIdle, StDone: begin
        if (run) begin
          tp_d    = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (gate) begin
          fence_d = f_fence;
          cav_d   = f_cav;
          cnt_d   = f_ifn;
          r0v_d   = frame[R0vLsb +: NUM_CORES];
          r0_d    = frame[R0Lsb +: NUM_CORES*REG_W];
          tp_d    = tp_q + AW'(1);
          if (f_fence == FenceEnd) begin
            state_d = StDone;
          end else if (f_ifn == '0) begin
            state_d = StFetch;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (~|(cav_q & ~Ready)) begin
          start_d = cav_q;
          insn_d  = frame;
          tp_d    = tp_q + AW'(1);
          cnt_d   = cnt_q - IF_W'(1);
          if (cnt_q == IF_W'(1)) begin
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StFetch) || (state_d == StIssue);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      tp_q    <= '0;
      cnt_q   <= '0;
      fence_q <= FenceNo;
      cav_q   <= '0;
      start_q <= '0;
      insn_q  <= '0;
      r0v_q   <= '0;
      r0_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tp_q    <= tp_d;
      cnt_q   <= cnt_d;
      fence_q <= fence_d;
      cav_q   <= cav_d;
      start_q <= start_d;
      insn_q  <= insn_d;
      r0v_q   <= r0v_d;
      r0_q    <= r0_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Start        = start_q;
  assign Insn_Data    = insn_q;
  assign Init_R0_Vect = r0v_q;
  assign Init_R0      = r0_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_task_scheduler_fsm.sv
// Directed bench for task_scheduler_fsm: a 64-deep instance for ordering/stall/reset cases
// and an 8-deep instance for the task-pointer wrap.
module tb_task_scheduler_fsm;

  logic        clk;
  logic        reset;
  logic        tm_we;
  logic        we8;
  logic [5:0]  waddr;
  logic [63:0] wdata;
  logic        run;
  logic        run8;
  logic [3:0]  ready;

  logic [3:0]  start, start8;
  logic [63:0] insn, insn8;
  logic [3:0]  r0v, r0v8;
  logic [31:0] r0, r08;
  logic        busy, busy8, done, done8;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] InsA = 64'hA1A1_0000_0000_0001;
  localparam logic [63:0] InsB = 64'hB2B2_0000_0000_0002;
  localparam logic [63:0] InsC = 64'hC3C3_0000_0000_0003;
  localparam logic [63:0] InsD = 64'hD4D4_0000_0000_0004;
  localparam logic [63:0] InsE = 64'hE5E5_0000_0000_0005;
  localparam logic [63:0] InsF = 64'hF6F6_0000_0000_0006;
  localparam logic [63:0] Junk = 64'hDEAD_BEEF_DEAD_BEEF;

  task_scheduler_fsm u_dut (
    .clk          (clk),
    .reset        (reset),
    .tm_we        (tm_we),
    .tm_waddr     (waddr),
    .tm_wdata     (wdata),
    .run          (run),
    .Ready        (ready),
    .Start        (start),
    .Insn_Data    (insn),
    .Init_R0_Vect (r0v),
    .Init_R0      (r0),
    .busy         (busy),
    .done         (done)
  );

  task_scheduler_fsm #(.TM_DEPTH(8)) u_dut8 (
    .clk          (clk),
    .reset        (reset),
    .tm_we        (we8),
    .tm_waddr     (waddr[2:0]),
    .tm_wdata     (wdata),
    .run          (run8),
    .Ready        (ready),
    .Start        (start8),
    .Insn_Data    (insn8),
    .Init_R0_Vect (r0v8),
    .Init_R0      (r08),
    .busy         (busy8),
    .done         (done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ctrl(input logic [1:0] f, input logic [3:0] cav,
                                       input logic [3:0] rv, input logic [3:0] ifn,
                                       input logic [31:0] rv0);
    logic [63:0] w;
    w        = '0;
    w[1:0]   = f;
    w[5:2]   = cav;
    w[9:6]   = rv;
    w[13:10] = ifn;
    w[45:14] = rv0;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [63:0] d);
    waddr = a; wdata = d; tm_we = 1'b1;
    step();
    tm_we = 1'b0;
  endtask

  task automatic wr8(input logic [5:0] a, input logic [63:0] d);
    waddr = a; wdata = d; we8 = 1'b1;
    step();
    we8 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tm_we = 1'b0; we8 = 1'b0; waddr = '0; wdata = '0;
    run = 1'b0; run8 = 1'b0; ready = 4'hF;
    step(); step();
    chk("rst start", 64'(start), 64'h0);
    chk("rst insn", insn, 64'h0);
    chk("rst busy", 64'(busy), 64'h0);
    chk("rst done", 64'(done), 64'h0);
    chk("rst r0v", 64'(r0v), 64'h0);
    chk("rst r0", 64'(r0), 64'h0);
    chk("rst start8", 64'(start8), 64'h0);
    reset = 1'b0;

    // 1: two back-to-back issues then END
    wr(0, ctrl(2'd0, 4'b0011, 4'h0, 4'd2, 32'h0));
    wr(1, InsA);
    wr(2, InsB);
    wr(3, ctrl(2'd3, 4'h0, 4'h0, 4'd0, 32'h0));
    run = 1'b1; step(); run = 1'b0;
    chk("t1 busy", 64'(busy), 64'h1);
    step();
    chk("t1 accept nostart", 64'(start), 64'h0);
    step();
    chk("t1 start1", 64'(start), 64'h3);
    chk("t1 insn1", insn, InsA);
    step();
    chk("t1 start2", 64'(start), 64'h3);
    chk("t1 insn2", insn, InsB);
    step();
    chk("t1 start off", 64'(start), 64'h0);
    chk("t1 done", 64'(done), 64'h1);
    chk("t1 idle", 64'(busy), 64'h0);
    step();
    chk("t1 done held", 64'(done), 64'h1);

    // 2: Ready[1] low for 5 ISSUE cycles
    run = 1'b1; step(); run = 1'b0;
    chk("t2 done clr", 64'(done), 64'h0);
    step();
    ready = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2 stall", 64'(start), 64'h0);
    end
    ready = 4'hF;
    step();
    chk("t2 resume1", 64'(start), 64'h3);
    chk("t2 insn1", insn, InsA);
    step();
    chk("t2 resume2", 64'(start), 64'h3);
    chk("t2 insn2", insn, InsB);
    step();
    chk("t2 done", 64'(done), 64'h1);

    // 3: REL frame waits for the whole array
    wr(0, ctrl(2'd0, 4'b0001, 4'h0, 4'd1, 32'h0));
    wr(1, InsC);
    wr(2, ctrl(2'd2, 4'b0100, 4'h0, 4'd1, 32'h0));
    wr(3, InsD);
    wr(4, ctrl(2'd3, 4'h0, 4'h0, 4'd0, 32'h0));
    run = 1'b1; step(); run = 1'b0;
    step();
    step();
    chk("t3 start c0", 64'(start), 64'h1);
    chk("t3 insn c0", insn, InsC);
    ready = 4'b1110;
    step();
    step();
    chk("t3 rel stall", 64'(start), 64'h0);
    step();
    ready = 4'hF;
    step();
    chk("t3 rel accept", 64'(start), 64'h0);
    step();
    chk("t3 start c2", 64'(start), 64'h4);
    chk("t3 insn c2", insn, InsD);
    step();
    chk("t3 done", 64'(done), 64'h1);

    // 4: R0 init latched at accept, held through ISSUE
    wr(0, ctrl(2'd0, 4'b0001, 4'b1010, 4'd1, 32'h4433_2211));
    wr(1, InsE);
    wr(2, ctrl(2'd3, 4'h0, 4'h0, 4'd0, 32'h0));
    run = 1'b1; step(); run = 1'b0;
    chk("t4 pre r0v", 64'(r0v), 64'h0);
    step();
    chk("t4 r0v", 64'(r0v), 64'hA);
    chk("t4 r0", 64'(r0), 64'h4433_2211);
    step();
    chk("t4 issue start", 64'(start), 64'h1);
    chk("t4 held r0v", 64'(r0v), 64'hA);
    chk("t4 held r0", 64'(r0), 64'h4433_2211);
    step();
    chk("t4 done", 64'(done), 64'h1);
    chk("t4 end r0v", 64'(r0v), 64'h0);

    // 5: 8-deep memory, skip frames 1..5, program 6,7,0 then END at 1
    wr8(0, ctrl(2'd0, 4'h0, 4'h0, 4'd5, 32'h0));
    wr8(1, ctrl(2'd3, 4'h0, 4'h0, 4'd0, 32'h0));
    for (int a = 2; a < 6; a++) wr8(6'(a), 64'h0);
    wr8(6, ctrl(2'd0, 4'b0001, 4'h0, 4'd2, 32'h0));
    wr8(7, InsF);
    run8 = 1'b1; step(); run8 = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5 skip", 64'(start8), 64'h0);
    end
    step();
    chk("t5 accept6", 64'(start8), 64'h0);
    step();
    chk("t5 start7", 64'(start8), 64'h1);
    chk("t5 insn7", insn8, InsF);
    step();
    chk("t5 start0", 64'(start8), 64'h1);
    chk("t5 insn0 wrap", insn8, ctrl(2'd0, 4'h0, 4'h0, 4'd5, 32'h0));
    step();
    chk("t5 done", 64'(done8), 64'h1);
    chk("t5 idle", 64'(busy8), 64'h0);

    // 6: write while busy is ignored, reset mid-ISSUE
    wr(0, ctrl(2'd0, 4'b0011, 4'h0, 4'd2, 32'h0));
    wr(1, InsA);
    wr(2, InsB);
    wr(3, ctrl(2'd3, 4'h0, 4'h0, 4'd0, 32'h0));
    run = 1'b1; step(); run = 1'b0;
    step();
    waddr = 6'd2; wdata = Junk; tm_we = 1'b1;
    step();
    tm_we = 1'b0;
    chk("t6 start1", 64'(start), 64'h3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6 rst start", 64'(start), 64'h0);
    chk("t6 rst busy", 64'(busy), 64'h0);
    chk("t6 rst insn", insn, 64'h0);
    run = 1'b1; step(); run = 1'b0;
    step();
    step();
    chk("t6 rerun insn1", insn, InsA);
    step();
    chk("t6 mem kept", insn, InsB);
    step();
    chk("t6 done", 64'(done), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
